// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: forwarding selects, FSM states, default widths.
package hazard_pkg;
  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HZ_IDLE,
    HZ_FLUSH,
    HZ_MEM_WAIT
  } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard unit bundle; master is the pipeline side, slave is the hazard unit.
interface hazard_ctrl_unit_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] rs1_d_i, rs2_d_i, rs1_ex_i, rs2_ex_i;
  logic [REG_ADDR_W-1:0] rd_ex_i, rd_mem_i, rd_wb_i;
  logic                  regwen_ex_i, regwen_mem_i, regwen_wb_i;
  logic                  memrd_ex_i, pc_taken_i, dmem_req_i, dmem_ack_i;
  fwd_sel_e              fwd_a_o, fwd_b_o;
  logic                  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic                  flush_id_o, flush_ex_o, flush_wb_o, mem_err_o;
  logic [CNT_W-1:0]      stall_cnt_o, flush_cnt_o;

  modport master (
    output rs1_d_i, rs2_d_i, rs1_ex_i, rs2_ex_i, rd_ex_i, rd_mem_i, rd_wb_i,
           regwen_ex_i, regwen_mem_i, regwen_wb_i, memrd_ex_i, pc_taken_i,
           dmem_req_i, dmem_ack_i,
    input  fwd_a_o, fwd_b_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, flush_wb_o, mem_err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  rs1_d_i, rs2_d_i, rs1_ex_i, rs2_ex_i, rd_ex_i, rd_mem_i, rd_wb_i,
           regwen_ex_i, regwen_mem_i, regwen_wb_i, memrd_ex_i, pc_taken_i,
           dmem_req_i, dmem_ack_i,
    output fwd_a_o, fwd_b_o, stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
           flush_id_o, flush_ex_o, flush_wb_o, mem_err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// One EX operand forwarding select; the MEM producer is younger and so wins over WB.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  regwen_mem,
  input  logic                  regwen_wb,
  output fwd_sel_e              sel
);
  always_comb begin
    sel = FWD_NONE;
    if (regwen_mem && (rd_mem != '0) && (rd_mem == rs))   sel = FWD_MEM;
    else if (regwen_wb && (rd_wb != '0) && (rd_wb == rs)) sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: forwarding, load-use bubble, branch flush, data-access wait with timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  hazard_ctrl_unit_if.slave hz
);
  localparam logic [1:0] BR_RELOAD = 2'(BR_PENALTY - 1);
  localparam logic [7:0] TMO       = 8'(MEM_TIMEOUT);

  hz_state_e  state_q, state_d, ret_q, ret_d, cur;
  logic [1:0] br_cnt_q, br_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  fwd_sel_e   sel_a, sel_b;
  logic       mem_wait, load_use, timeout;
  logic       st_if, st_id, st_ex, st_mem, fl_id, fl_ex, fl_wb, err;
  logic       unused_regwen_ex;

  assign unused_regwen_ex = hz.regwen_ex_i;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(hz.rs1_ex_i), .rd_mem(hz.rd_mem_i), .rd_wb(hz.rd_wb_i),
    .regwen_mem(hz.regwen_mem_i), .regwen_wb(hz.regwen_wb_i), .sel(sel_a)
  );
  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(hz.rs2_ex_i), .rd_mem(hz.rd_mem_i), .rd_wb(hz.rd_wb_i),
    .regwen_mem(hz.regwen_mem_i), .regwen_wb(hz.regwen_wb_i), .sel(sel_b)
  );

  assign mem_wait = hz.dmem_req_i & ~hz.dmem_ack_i;
  assign load_use = hz.memrd_ex_i & (hz.rd_ex_i != '0) &
                    ((hz.rd_ex_i == hz.rs1_d_i) | (hz.rd_ex_i == hz.rs2_d_i));
  assign timeout  = (state_q == HZ_MEM_WAIT) && (wait_cnt_q == TMO);
  // While waiting, the state to resume is what governs the ack cycle.
  assign cur      = (state_q == HZ_MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    br_cnt_d   = br_cnt_q;
    wait_cnt_d = wait_cnt_q;
    {st_if, st_id, st_ex, st_mem, fl_id, fl_ex, fl_wb, err} = '0;
    if (timeout) begin
      err        = 1'b1;
      state_d    = HZ_IDLE;
      wait_cnt_d = '0;
    end else if (mem_wait) begin
      {st_if, st_id, st_ex, st_mem, fl_wb} = '1;
      state_d    = HZ_MEM_WAIT;
      ret_d      = cur;
      wait_cnt_d = (state_q == HZ_MEM_WAIT) ? wait_cnt_q + 8'd1 : 8'd1;
    end else begin
      state_d    = HZ_IDLE;
      wait_cnt_d = '0;
      if (hz.pc_taken_i) begin
        {fl_id, fl_ex} = '1;
        if (BR_PENALTY > 1) begin
          br_cnt_d = BR_RELOAD;
          state_d  = HZ_FLUSH;
        end
      end else if (cur == HZ_FLUSH) begin
        {fl_id, fl_ex} = '1;
        br_cnt_d = br_cnt_q - 2'd1;
        state_d  = (br_cnt_q == 2'd1) ? HZ_IDLE : HZ_FLUSH;
      end else if (load_use) begin
        {st_if, st_id, fl_ex} = '1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= HZ_IDLE;
      ret_q      <= HZ_IDLE;
      br_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      br_cnt_q   <= br_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign hz.fwd_a_o     = rst_ni ? sel_a : FWD_NONE;
  assign hz.fwd_b_o     = rst_ni ? sel_b : FWD_NONE;
  assign hz.stall_if_o  = rst_ni & st_if;
  assign hz.stall_id_o  = rst_ni & st_id;
  assign hz.stall_ex_o  = rst_ni & st_ex;
  assign hz.stall_mem_o = rst_ni & st_mem;
  assign hz.flush_id_o  = rst_ni & fl_id;
  assign hz.flush_ex_o  = rst_ni & fl_ex;
  assign hz.flush_wb_o  = rst_ni & fl_wb;
  assign hz.mem_err_o   = rst_ni & err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.stall_if_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (hz.flush_id_o && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
`else
  assign hz.stall_cnt_o = {CNT_W{1'b0}};
  assign hz.flush_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (BR_PENALTY=3, MEM_TIMEOUT=16).
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

  hazard_ctrl_unit #(
    .REG_ADDR_W(5), .BR_PENALTY(3), .MEM_TIMEOUT(16), .CNT_W(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .hz(hz)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic [2:0] wen;    // {ex, mem, wb}
    logic       memrd;
    logic [1:0] a, b;
    logic [2:0] s;      // {stall_if, stall_id, flush_ex}
  } vec_t;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {fwd_a, fwd_b, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, mem_err}
  function automatic logic [11:0] outw();
    return {hz.fwd_a_o, hz.fwd_b_o, hz.stall_if_o, hz.stall_id_o, hz.stall_ex_o,
            hz.stall_mem_o, hz.flush_id_o, hz.flush_ex_o, hz.flush_wb_o, hz.mem_err_o};
  endfunction

  task automatic clear_in();
    hz.rs1_d_i = '0; hz.rs2_d_i = '0; hz.rs1_ex_i = '0; hz.rs2_ex_i = '0;
    hz.rd_ex_i = '0; hz.rd_mem_i = '0; hz.rd_wb_i = '0;
    hz.regwen_ex_i = 1'b0; hz.regwen_mem_i = 1'b0; hz.regwen_wb_i = 1'b0;
    hz.memrd_ex_i = 1'b0; hz.pc_taken_i = 1'b0;
    hz.dmem_req_i = 1'b0; hz.dmem_ack_i = 1'b0;
  endtask

  task automatic load_use_in();
    hz.memrd_ex_i = 1'b1; hz.rd_ex_i = 5'd7; hz.rs2_d_i = 5'd7;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[12];
    int n_si, n_fid, n_fex, n_smem, n_fwb, n_err;
    logic seen, st_at_err;

    tv[0]  = '{"fwd_a_mem_prio", 0, 0, 5, 3, 0, 5, 5, 3'b011, 0, 2'b01, 2'b00, 3'b000};
    tv[1]  = '{"fwd_a_wb",       0, 0, 5, 3, 0, 5, 5, 3'b001, 0, 2'b10, 2'b00, 3'b000};
    tv[2]  = '{"fwd_zero_reg",   0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 2'b00, 2'b00, 3'b000};
    tv[3]  = '{"fwd_b_mem_a_wb", 0, 0, 4, 9, 0, 9, 4, 3'b011, 0, 2'b10, 2'b01, 3'b000};
    tv[4]  = '{"fwd_b_wb_only",  0, 0, 1, 6, 0, 6, 6, 3'b001, 0, 2'b00, 2'b10, 3'b000};
    tv[5]  = '{"fwd_no_wen",     0, 0, 5, 5, 0, 5, 5, 3'b100, 0, 2'b00, 2'b00, 3'b000};
    tv[6]  = '{"lu_rs2",         0, 7, 0, 0, 7, 0, 0, 3'b100, 1, 2'b00, 2'b00, 3'b111};
    tv[7]  = '{"lu_rs1",        12, 3, 0, 0,12, 0, 0, 3'b100, 1, 2'b00, 2'b00, 3'b111};
    tv[8]  = '{"lu_rd0",         0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 2'b00, 2'b00, 3'b000};
    tv[9]  = '{"lu_not_load",    7, 0, 0, 0, 7, 0, 0, 3'b100, 0, 2'b00, 2'b00, 3'b000};
    tv[10] = '{"lu_no_match",    3, 8, 0, 0, 7, 0, 0, 3'b100, 1, 2'b00, 2'b00, 3'b000};
    tv[11] = '{"lu_with_fwd",    2, 0, 2, 0, 2, 2, 0, 3'b110, 1, 2'b01, 2'b00, 3'b111};

    // Reset with every hazard input active: outputs must stay quiet.
    clear_in();
    load_use_in();
    hz.pc_taken_i = 1'b1; hz.dmem_req_i = 1'b1;
    hz.regwen_mem_i = 1'b1; hz.rd_mem_i = 5'd5; hz.rs1_ex_i = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(outw()), 0);
    chk("reset_stall_cnt", hz.stall_cnt_o, 0);
    chk("reset_flush_cnt", hz.flush_cnt_o, 0);
    cyc(); clear_in(); rst_n = 1'b1;

    foreach (tv[i]) begin
      cyc(); clear_in();
      hz.rs1_d_i = tv[i].rs1_d; hz.rs2_d_i = tv[i].rs2_d;
      hz.rs1_ex_i = tv[i].rs1_ex; hz.rs2_ex_i = tv[i].rs2_ex;
      hz.rd_ex_i = tv[i].rd_ex; hz.rd_mem_i = tv[i].rd_mem; hz.rd_wb_i = tv[i].rd_wb;
      {hz.regwen_ex_i, hz.regwen_mem_i, hz.regwen_wb_i} = tv[i].wen;
      hz.memrd_ex_i = tv[i].memrd;
      @(negedge clk);
      chk(tv[i].name, 32'(outw()),
          32'({tv[i].a, tv[i].b, tv[i].s[2], tv[i].s[1], 3'b000, tv[i].s[0], 2'b00}));
    end

    // Load-use applied for one cycle gives exactly one bubble.
    n_si = 0; n_fex = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(); clear_in();
      if (c == 0) load_use_in();
      @(negedge clk);
      n_si += int'(hz.stall_if_o); n_fex += int'(hz.flush_ex_o);
    end
    chk("lu_one_bubble_stall", n_si, 1);
    chk("lu_one_bubble_flush_ex", n_fex, 1);

    // Single taken branch: BR_PENALTY flush cycles.
    n_fid = 0; n_fex = 0; n_si = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(); clear_in();
      hz.pc_taken_i = (c == 0);
      @(negedge clk);
      n_fid += int'(hz.flush_id_o); n_fex += int'(hz.flush_ex_o); n_si += int'(hz.stall_if_o);
    end
    chk("br_single_flush_id", n_fid, 3);
    chk("br_single_flush_ex", n_fex, 3);
    chk("br_single_no_stall", n_si, 0);

    // Second taken branch on the following cycle extends the window to 4.
    n_fid = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(); clear_in();
      hz.pc_taken_i = (c < 2);
      @(negedge clk);
      n_fid += int'(hz.flush_id_o);
    end
    chk("br_double_flush_id", n_fid, 4);

    // Branch and load-use together: flush only.
    cyc(); clear_in(); load_use_in(); hz.pc_taken_i = 1'b1;
    @(negedge clk);
    chk("br_beats_load_use", 32'(outw()), 32'h00C);
    repeat (4) begin cyc(); clear_in(); end

    // Data access acked after 4 stalled cycles.
    n_smem = 0; n_fwb = 0; n_err = 0; n_si = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(); clear_in();
      hz.dmem_req_i = (c <= 4); hz.dmem_ack_i = (c == 4);
      @(negedge clk);
      n_smem += int'(hz.stall_mem_o); n_fwb += int'(hz.flush_wb_o);
      n_err += int'(hz.mem_err_o); n_si += int'(hz.stall_if_o);
    end
    chk("mw_stall_mem_cycles", n_smem, 4);
    chk("mw_flush_wb_cycles", n_fwb, 4);
    chk("mw_stall_if_cycles", n_si, 4);
    chk("mw_no_err", n_err, 0);

    // Taken branch held through a wait is acted on only at ack.
    n_fid = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(); clear_in();
      hz.dmem_req_i = (c <= 2); hz.dmem_ack_i = (c == 2); hz.pc_taken_i = (c <= 2);
      @(negedge clk);
      if (c == 0) chk("mw_overrides_branch", 32'(outw()), 32'h0F2);
      n_fid += int'(hz.flush_id_o);
    end
    chk("mw_branch_after_ack", n_fid, 3);

    // Wait arriving mid-FLUSH preserves the remaining flush cycle.
    n_fid = 0; n_si = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(); clear_in();
      hz.pc_taken_i = (c == 0);
      hz.dmem_req_i = (c >= 2 && c <= 4); hz.dmem_ack_i = (c == 4);
      @(negedge clk);
      if (c == 2) chk("flush_mw_stall_only", 32'(outw()), 32'h0F2);
      n_fid += int'(hz.flush_id_o); n_si += int'(hz.stall_if_o);
    end
    chk("flush_mw_resume_flush", n_fid, 3);
    chk("flush_mw_stalls", n_si, 2);

    // Never-acked access: 16 stalled cycles then one error pulse.
    seen = 1'b0; st_at_err = 1'b1; n_smem = 0; n_err = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(); clear_in();
      hz.dmem_req_i = !seen;
      @(negedge clk);
      if (hz.mem_err_o) begin
        n_err++;
        if (!seen) st_at_err = hz.stall_if_o | hz.stall_mem_o | hz.flush_wb_o;
        seen = 1'b1;
      end else if (!seen) begin
        n_smem += int'(hz.stall_mem_o);
      end
    end
    chk("tmo_stall_cycles", n_smem, 16);
    chk("tmo_err_pulses", n_err, 1);
    chk("tmo_stalls_dropped", 32'(st_at_err), 0);
    cyc(); clear_in(); hz.pc_taken_i = 1'b1;
    @(negedge clk);
    chk("tmo_back_to_idle", 32'(outw()), 32'h00C);

    // Reset mid-FLUSH discards the remaining flush cycles.
    cyc(); clear_in();
    cyc(); clear_in(); hz.pc_taken_i = 1'b1;
    @(negedge clk);
    cyc(); clear_in(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_flush_gated", 32'(outw()), 0);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_flush_discarded", 32'(outw()), 0);

    // Performance counters over 10 load-use events, then reset mid-wait.
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      cyc(); clear_in(); load_use_in();
      cyc(); clear_in();
    end
    @(negedge clk);
    chk("perf_stall_cnt", hz.stall_cnt_o, (PERF != 0) ? 32'd10 : 32'd0);
    chk("perf_flush_cnt", hz.flush_cnt_o, 0);
    repeat (3) begin cyc(); clear_in(); hz.dmem_req_i = 1'b1; end
    cyc(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mw_stalls_gated", 32'(outw()), 0);
    cyc(); rst_n = 1'b1; clear_in();
    @(negedge clk);
    chk("rst_mw_stall_cnt", hz.stall_cnt_o, 0);
    chk("rst_mw_flush_cnt", hz.flush_cnt_o, 0);
    chk("rst_mw_outputs", 32'(outw()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter REG_ADDR_W, 5, register-index width.
REQ-002 Parameter BR_PENALTY, 1, consecutive cycles flush_id_o/flush_ex_o held per taken branch; legal 1..3.
REQ-003 Parameter MEM_TIMEOUT, 16, maximum stall cycles waiting for dmem_ack_i; legal 2..255.
REQ-004 Parameter CNT_W, 32, performance-counter width.
REQ-005 One clock, clk_i; reset rst_ni is synchronous and active-low.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_ni  in  1  synchronous active-low reset.
REQ-008 rs1_d_i, rs2_d_i  in  REG_ADDR_W  source registers of the ID instruction.
REQ-009 rs1_ex_i, rs2_ex_i  in  REG_ADDR_W  source registers of the EX instruction.
REQ-010 rd_ex_i, rd_mem_i, rd_wb_i  in  REG_ADDR_W  destination registers in EX/MEM/WB.
REQ-011 regwen_ex_i, regwen_mem_i, regwen_wb_i  in  1  register write enables in EX/MEM/WB.
REQ-012 memrd_ex_i  in  1  EX instruction is a load.
REQ-013 pc_taken_i  in  1  branch/jump redirect this cycle.
REQ-014 dmem_req_i, dmem_ack_i  in  1  MEM-stage data access request and its completion.
REQ-015 fwd_a_o, fwd_b_o  out  2  EX operand forwarding select (00 none, 01 MEM, 10 WB).
REQ-016 stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out  1  hold stage register.
REQ-017 flush_id_o, flush_ex_o, flush_wb_o  out  1  insert bubble into stage register.
REQ-018 mem_err_o  out  1  one-cycle pulse on data-access timeout.
REQ-019 stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters.

Function
REQ-020 fwd_a_o SHALL be 01 when regwen_mem_i, rd_mem_i!=0 and rd_mem_i==rs1_ex_i; else 10 when the same holds for WB; else 00; MEM has priority; fwd_b_o identical using rs2_ex_i; combinational, zero latency.
REQ-021 Load-use hazard = memrd_ex_i & rd_ex_i!=0 & (rd_ex_i==rs1_d_i | rd_ex_i==rs2_d_i); SHALL assert stall_if_o, stall_id_o, flush_ex_o in that cycle only (exactly one bubble).
REQ-022 Mem wait = dmem_req_i & !dmem_ack_i; SHALL assert stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_wb_o combinationally; overrides all other actions (no flush_id_o/flush_ex_o, counter frozen).
REQ-023 FSM states IDLE, FLUSH, MEM_WAIT; registered state, combinational outputs.
REQ-024 IDLE: pc_taken_i without mem wait SHALL assert flush_id_o, flush_ex_o this cycle; if BR_PENALTY>1 load down-counter with BR_PENALTY-1 and go FLUSH.
REQ-025 FLUSH: assert flush_id_o, flush_ex_o; decrement; return to IDLE when counter reaches 0 after the decrement; new pc_taken_i reloads counter with BR_PENALTY-1.
REQ-026 Taken branch and load-use in same cycle: branch wins (flush only, no stall_if_o/stall_id_o).
REQ-027 Mem wait in IDLE or FLUSH: go MEM_WAIT, wait counter=1, FLUSH counter preserved; on ack resume previous state (IDLE or FLUSH).
REQ-028 MEM_WAIT: wait counter increments each un-acked cycle; reaching MEM_TIMEOUT SHALL pulse mem_err_o, drop all stalls for that cycle, and return to IDLE.
REQ-029 pc_taken_i during mem wait SHALL be ignored; the pipeline holds it and it is acted on after ack.
REQ-030 Register index 0 SHALL never cause forwarding or load-use stall.

Reset
REQ-031 While rst_ni=0 at a clk_i edge: state IDLE, all counters 0, mem_err_o 0.
REQ-032 While rst_ni=0 all stall/flush outputs SHALL be 0 and fwd outputs 00 regardless of inputs; reset mid-FLUSH or mid-MEM_WAIT discards state.

Configuration
REQ-033 Macro HAZARD_PERF_CNT_EN defined: stall_cnt_o counts cycles with stall_if_o=1, flush_cnt_o counts cycles with flush_id_o=1, both saturating at all-ones.
REQ-034 Macro undefined: counters not built; stall_cnt_o, flush_cnt_o tied to 0.

Structure
REQ-035 Package hazard_pkg SHALL hold fwd_sel_e (FWD_NONE=00, FWD_MEM=01, FWD_WB=10), hz_state_e, default REG_ADDR_W.
REQ-036 Sub-module hazard_fwd_sel SHALL compute one forwarding select; instantiated twice (A, B).

Verification
REQ-037 rd_mem=5 regwen_mem=1, rd_wb=5 regwen_wb=1, rs1_ex=5 -> fwd_a_o=01; clear regwen_mem -> 10; rd=0 -> 00.
REQ-038 memrd_ex=1 rd_ex=7 rs2_d=7 -> stall_if/stall_id/flush_ex high exactly 1 cycle.
REQ-039 BR_PENALTY=3, pc_taken 1 cycle -> flush_id_o high 3 cycles; second pc_taken in cycle 2 -> 4 cycles total.
REQ-040 dmem_req=1, ack after 4 cycles -> stall_mem_o high 4 cycles, flush_wb_o high 4 cycles, mem_err_o 0.
REQ-041 MEM_TIMEOUT=16, ack never -> mem_err_o pulses once after 16 stalled cycles, state IDLE.
REQ-042 HAZARD_PERF_CNT_EN, 10 load-use events -> stall_cnt_o=10; reset mid-MEM_WAIT -> counters 0, stalls 0.
